// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused)
//   DEFAULT_WIDTH : default operand/sum width
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder, time-shared by serial_add_ctrl.
// Ports:
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one
// bit per clock, through a single full_adder_cell with a registered carry.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request, sampled only in IDLE or DONE
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   busy       : high while the operation is running (WIDTH cycles)
//   done       : one-cycle pulse when sum/cout have just been updated
//   sum, cout  : registered result, held until the next completion
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               cell_s;
    logic               cell_co;
    logic [WIDTH-1:0]   res_next;

    full_adder_cell u_cell (
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .ci (carry_reg),
        .s  (cell_s),
        .co (cell_co)
    );

    // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_next = cell_s;
        end else begin : g_res_many
            assign res_next = {cell_s, res_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= cell_co;
                    res_reg   <= res_next;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BIT) begin
                        // Sum and carry-out publish together with the done pulse.
                        sum_reg   <= res_next;
                        cout_reg  <= cell_co;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): a transaction-level
// model predicts busy/done/sum/cout every cycle, plus directed literal checks.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an operation in flight is just "cycles remaining" plus the
    // arithmetic answer a+b+cin computed at acceptance.
    logic         exp_busy;
    logic         exp_done;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    int           run_left;
    logic [W:0]   pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_sum  = '0;
            exp_cout = 1'b0;
            run_left = 0;
            pend     = '0;
        end else if (exp_busy) begin
            run_left = run_left - 1;
            exp_done = 1'b0;
            if (run_left == 0) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
                exp_sum  = pend[W-1:0];
                exp_cout = pend[W];
            end
        end else begin
            exp_done = 1'b0;
            if (start) begin
                pend     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                run_left = W;
                exp_busy = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("busy", {31'b0, busy}, {31'b0, exp_busy});
        check("done", {31'b0, done}, {31'b0, exp_done});
        check("sum",  {24'b0, sum},  {24'b0, exp_sum});
        check("cout", {31'b0, cout}, {31'b0, exp_cout});
    end

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        @(posedge clk);
        #1;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("op a=%02h b=%02h cin=%0d", ta, tb_v, tc);
    endtask

    // Returns at the falling edge inside the done cycle.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done timeout got 0 expected 1", name);
        end
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] s, input logic c);
        check({name, "_model_sum"}, {24'b0, exp_sum}, {24'b0, s});
        check({name, "_sum"}, {24'b0, sum}, {24'b0, s});
        check({name, "_cout"}, {31'b0, cout}, {31'b0, c});
        $display("result %s sum=%02h cout=%0d", name, sum, cout);
    endtask

    initial begin
        int busy_cycles;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // 1. reset
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum",  {24'b0, sum},  32'h00);
        check("rst_cout", {31'b0, cout}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 2. basic add, measure busy length
        start_op(8'h3C, 8'h0F, 1'b0);
        busy_cycles = 0;
        @(negedge clk);
        while (busy && busy_cycles < 30) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("busy_len", busy_cycles, 32'd8);
        check("done_after_busy", {31'b0, done}, 32'd1);
        expect_result("t2", 8'h4B, 1'b0);

        // 3. wrap-around
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done("t3a");
        expect_result("t3a", 8'h00, 1'b1);
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done("t3b");
        expect_result("t3b", 8'hFF, 1'b1);

        // 4. start and operand change mid-run are ignored
        start_op(8'h3C, 8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; a = 8'h00; b = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4");
        expect_result("t4", 8'h4B, 1'b0);

        // 5. asynchronous reset mid-run
        start_op(8'hAA, 8'h55, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_sum",  {24'b0, sum},  32'h00);
        check("arst_cout", {31'b0, cout}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        start_op(8'h01, 8'h01, 1'b0);
        wait_done("t5");
        expect_result("t5", 8'h02, 1'b0);

        // 6. back-to-back acceptance in the done cycle
        start_op(8'h05, 8'h06, 1'b0);
        wait_done("t6a");
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        check("b2b_hold", {24'b0, sum}, 32'h0B);
        wait_done("t6b");
        expect_result("t6b", 8'h30, 1'b0);

        // Randomized operations, some with noise pulses and back-to-back starts
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            start_op(ra, rb, rc);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1 start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_done("rand");
            $display("rand %0d a=%02h b=%02h cin=%0d sum=%02h cout=%0d", i, ra, rb, rc, sum, cout);
            if ($urandom_range(0, 2) == 0) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                wait_done("rand_b2b");
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
